// File: rtl/snoop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : snoop_pkg                                                    |
// | Description : Shared definitions for the snooping-coherence instruction    |
// |               feeder: instruction field positions, the idle CPU code, the  |
// |               default idle instruction and the issue FSM state type.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package snoop_pkg;

  // Instruction layout: [15:14] cpu, [13] op, [12:8] addr, [7:0] data
  localparam int CPU_HI  = 15;
  localparam int CPU_LO  = 14;
  localparam int OP_BIT  = 13;
  localparam int ADDR_HI = 12;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;

  // cpu code ignored by the snooping top; used to build the idle instruction
  localparam logic [1:0]  CPU_NONE           = 2'b11;
  localparam logic [15:0] IDLE_INSTR_DEFAULT = {CPU_NONE, 14'h0000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issue_state_t;

  // True when an instruction carries the no-op cpu code (an explicit bubble)
  function automatic logic is_bubble(input logic [15:0] instr);
    return instr[CPU_HI:CPU_LO] == CPU_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_instr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snoop_instr_fifo                                             |
// | Description : Power-of-two depth synchronous FIFO holding queued           |
// |               coherence instructions. Head data is presented               |
// |               combinationally; push and pop may occur in the same cycle.   |
// | Ports       : clock, reset (sync, active-high), flush (empties FIFO),      |
// |               push/push_data, pop/pop_data, count, full, empty             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module snoop_instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == (c_AW+1)'(DEPTH));
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/snoop_instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snoop_instr_issue                                            |
// | Description : Buffers 16-bit coherence instructions from a loader and      |
// |               drives them onto the snooping top's instruction bus. Each    |
// |               instruction is held HOLD_CYCLES, followed by GAP_CYCLES of   |
// |               IDLE_INSTR.                                                  |
// | Ports       : clock, reset (sync, active-high)                             |
// |               push_valid/push_instr/push_ready : loader handshake          |
// |               pause : block new issues; flush : empty FIFO, abort issue    |
// |               instruction (registered), issue_start (first-cycle pulse),   |
// |               busy, fifo_count, issued_count (wrapping), drop_err (sticky) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module snoop_instr_issue
  import snoop_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          HOLD_CYCLES = 4,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [15:0] IDLE_INSTR  = IDLE_INSTR_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [15:0]            push_instr,
  output logic                   push_ready,
  input  logic                   pause,
  input  logic                   flush,
  output logic [15:0]            instruction,
  output logic                   issue_start,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            issued_count,
  output logic                   drop_err
);

  localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  issue_state_t        r_state;
  issue_state_t        w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [15:0]         r_instr;
  logic [15:0]         w_instr_nxt;
  logic                r_issue_start;
  logic                w_issue_start_nxt;
  logic [15:0]         r_issued_count;
  logic                r_drop_err;

  logic                w_pd;
  logic                w_pop;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [15:0]         w_fifo_head;

  // A pop in the same cycle does not free a slot for the loader.
  assign push_ready = !w_fifo_full && !flush && !reset;
  assign w_push     = push_valid && push_ready;

  snoop_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (w_push),
    .push_data (push_instr),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .count     (fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Next-state logic. w_pd marks a pop-decision point: IDLE, the last
  // GAP cycle, or the last ISSUE cycle when there is no gap.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_instr_nxt       = r_instr;
    w_issue_start_nxt = 1'b0;
    w_pd              = 1'b0;
    w_pop             = 1'b0;

    case (r_state)
      IDLE: begin
        w_pd = 1'b1;
      end
      ISSUE: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = c_CNT_W'(GAP_CYCLES - 1);
            w_instr_nxt = IDLE_INSTR;
          end else begin
            w_pd = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_pd = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_pd = 1'b1;
      end
    endcase

    if (w_pd) begin
      w_pop = !w_fifo_empty && !pause && !flush;
      if (w_pop) begin
        w_state_nxt       = ISSUE;
        w_cnt_nxt         = c_CNT_W'(HOLD_CYCLES - 1);
        w_instr_nxt       = w_fifo_head;
        w_issue_start_nxt = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_instr_nxt = IDLE_INSTR;
      end
    end

    // flush aborts whatever is in flight
    if (flush) begin
      w_state_nxt       = IDLE;
      w_cnt_nxt         = '0;
      w_instr_nxt       = IDLE_INSTR;
      w_issue_start_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_instr        <= IDLE_INSTR;
      r_issue_start  <= 1'b0;
      r_issued_count <= '0;
      r_drop_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_instr       <= w_instr_nxt;
      r_issue_start <= w_issue_start_nxt;
      // counted at the pop so the value is current during issue_start
      if (w_pop) begin
        r_issued_count <= r_issued_count + 16'd1;
      end
      if (push_valid && !push_ready && !flush) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign instruction  = r_instr;
  assign issue_start  = r_issue_start;
  assign issued_count = r_issued_count;
  assign drop_err     = r_drop_err;
  assign busy         = (r_state != IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_snoop_instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_snoop_instr_issue                                         |
// | Description : Scoreboard bench for snoop_instr_issue. A transaction-level  |
// |               model predicts per-cycle handshake/status values and the     |
// |               instruction schedule; a negedge monitor compares them.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_snoop_instr_issue;

  localparam int          DEPTH  = 8;
  localparam int          HOLD   = 4;
  localparam int          GAP    = 1;
  localparam logic [15:0] IDLE_I = 16'hC000;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [15:0] push_instr;
  logic        push_ready;
  logic        pause;
  logic        flush;
  logic [15:0] instruction;
  logic        issue_start;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] issued_count;
  logic        drop_err;

  snoop_instr_issue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .IDLE_INSTR  (IDLE_I)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_instr   (push_instr),
    .push_ready   (push_ready),
    .pause        (pause),
    .flush        (flush),
    .instruction  (instruction),
    .issue_start  (issue_start),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .issued_count (issued_count),
    .drop_err     (drop_err)
  );

  always #5 clock = ~clock;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic ready;
    int   count;
    logic busy;
    logic drop;
  } cyc_exp_t;

  typedef struct {
    int          c;
    logic [15:0] instr;
    logic [15:0] num;
  } issue_exp_t;

  // Reference model: queued entries, end of the current activity window,
  // sticky drop flag, running issue number, and the bus schedule.
  logic [15:0] mq [$];
  int          act_end  = -1;
  logic        m_drop   = 1'b0;
  logic [15:0] m_issued = 16'd0;
  logic [15:0] exp_instr [int];
  cyc_exp_t    cyc_q [$];
  issue_exp_t  iq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Predicts the effect of the inputs currently applied for this cycle.
  task automatic model_step();
    int          cur;
    logic        rdy;
    logic [15:0] d;
    cyc_exp_t    e;
    cur = cyc;
    rdy = (mq.size() < DEPTH) && !flush;
    e.c     = cur;
    e.ready = rdy;
    e.count = mq.size();
    e.busy  = (cur <= act_end) || (mq.size() != 0);
    e.drop  = m_drop;
    cyc_q.push_back(e);
    if (flush) begin
      mq.delete();
      act_end = cur;
      for (int k = cur + 1; k <= cur + HOLD + GAP; k++) begin
        if (exp_instr.exists(k)) exp_instr.delete(k);
      end
    end else begin
      // a new instruction may start once the previous window has ended
      if (cur >= act_end && mq.size() != 0 && !pause) begin
        d = mq.pop_front();
        m_issued = m_issued + 16'd1;
        for (int k = 0; k < HOLD; k++) exp_instr[cur + 1 + k] = d;
        iq.push_back('{cur + 1, d, m_issued});
        act_end = cur + HOLD + GAP;
      end
      if (push_valid && rdy) mq.push_back(push_instr);
      if (push_valid && !rdy) m_drop = 1'b1;
    end
  endtask

  task automatic drive(input logic pv, input logic [15:0] pi, input logic pa, input logic fl);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    push_valid = pv;
    push_instr = pi;
    pause      = pa;
    flush      = fl;
    model_step();
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n, input logic pa);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, pa, 1'b0);
  endtask

  // Monitor: compares every cycle against the scoreboard queues.
  cyc_exp_t   mon_e;
  issue_exp_t mon_i;
  logic [15:0] mon_ei;
  logic        mon_is;

  always @(negedge clock) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        check("cyc_q_size", 32'(cyc_q.size()), 32'd1);
      end else begin
        mon_e = cyc_q.pop_front();
        check("cycle_sync", 32'(cyc), 32'(mon_e.c));
        check("push_ready", 32'(push_ready), 32'(mon_e.ready));
        check("fifo_count", 32'(fifo_count), 32'(mon_e.count));
        check("busy", 32'(busy), 32'(mon_e.busy));
        check("drop_err", 32'(drop_err), 32'(mon_e.drop));
      end
      mon_ei = IDLE_I;
      if (exp_instr.exists(cyc)) begin
        mon_ei = exp_instr[cyc];
        exp_instr.delete(cyc);
      end
      check("instruction", 32'(instruction), 32'(mon_ei));
      mon_is = (iq.size() != 0) && (iq[0].c == cyc);
      check("issue_start", 32'(issue_start), 32'(mon_is));
      if (mon_is) begin
        mon_i = iq.pop_front();
        check("issued_count", 32'(issued_count), 32'(mon_i.num));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    push_valid = 1'b1;
    push_instr = 16'h1234;
    pause      = 1'b0;
    flush      = 1'b0;

    // Reset held three cycles with a push offered
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_instruction", 32'(instruction), 32'h0000C000);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_issued_count", 32'(issued_count), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_issue_start", 32'(issue_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single issue
    drive(1'b1, 16'h2855, 1'b0, 1'b0);
    idle(8, 1'b0);

    // Back-to-back issue
    drive(1'b1, 16'h2855, 1'b0, 1'b0);
    drive(1'b1, 16'h4A00, 1'b0, 1'b0);
    idle(12, 1'b0);

    // Fill while paused, ninth push is dropped, then drain in order
    for (int i = 0; i < 9; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    idle(50, 1'b0);

    // Flush on the second hold cycle with entries queued and a push offered
    drive(1'b1, 16'h2A11, 1'b0, 1'b0);
    drive(1'b1, 16'h2A22, 1'b0, 1'b0);
    drive(1'b1, 16'hC0FF, 1'b0, 1'b0);
    drive(1'b1, 16'h2A33, 1'b0, 1'b1);
    idle(6, 1'b0);

    // Pause raised in the gap cycle, held, then released
    drive(1'b1, 16'h6B01, 1'b0, 1'b0);
    drive(1'b1, 16'h6B02, 1'b0, 1'b0);
    drive(1'b1, 16'h6B03, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);
    idle(20, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 59) == 0);
    end
    idle(60, 1'b0);

    @(negedge clock);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
